mips_decode_alu: RTL and testbench
==================================

Name: mips_decode_alu

Overview:
- Single-issue MIPS decode/execute slice: main control decoder (opcode to datapath controls), ALU control decoder (aluop + funct to 4-bit ALU op), and a 32-bit ALU.
- Control and ALU-op outputs are combinational.
- ALU result, zero flag and valid are registered with one-cycle latency.
- Sits between ID and EX of the five-stage CPU pipeline.

Parameters:
- W, 32, datapath width. Only 32 is supported.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high; clears registered outputs
- in_valid  in  1  operands/instruction fields valid this cycle
- opcode  in  6  instr[31:26]
- funct  in  6  instr[5:0]
- imm  in  16  instr[15:0], sign-extended internally
- a  in  32  rs operand
- b  in  32  rt operand
- regdst  out  1  comb; 1 = write rd, 0 = write rt
- branch  out  1  comb; beq
- memread  out  1  comb
- memwrite  out  1  comb
- memtoreg  out  1  comb
- aluop  out  2  comb
- regwrite  out  1  comb
- alusrc  out  1  comb; 1 = ALU B operand is sign-extended imm
- aluctl  out  4  comb ALU operation
- result  out  32  registered ALU output
- zero  out  1  registered; result == 0
- out_valid  out  1  registered in_valid

Behaviour:
- Main decode, outputs listed as {regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}:
  - 000000 R-type: 1,0,0,1,0,0,0,10
  - 100011 lw: 0,1,1,1,1,0,0,00
  - 101011 sw: 0,1,0,0,0,1,0,00
  - 000100 beq: 0,0,0,0,0,0,1,01
  - 001000 addi: 0,1,0,1,0,0,0,00
  - Any other opcode: all zero (acts as NOP; no write, no memory access).
- ALU control:
  - aluop 00: 0010 (add).
  - aluop 01: 0110 (sub).
  - aluop 10, by funct:
    - 100000 add: 0010
    - 100010 sub: 0110
    - 100100 and: 0000
    - 100101 or: 0001
    - 101010 slt: 0111
    - 100111 nor: 1100
    - Any other funct: 0010.
  - aluop 11: 0010.
- ALU, B operand = alusrc ? {{16{imm[15]}}, imm} : b:
  - 0000: a & B
  - 0001: a | B
  - 0010: a + B, modulo 2^32, no overflow trap
  - 0110: a - B, modulo 2^32
  - 0111: slt, 32'd1 if $signed(a) < $signed(B), else 0
  - 1100: ~(a | B)
  - Any other code: 0.
- Timing:
  - On each rising clk with reset=0: result <= ALU output; zero <= (ALU output == 0); out_valid <= in_valid.
  - result/zero update every cycle regardless of in_valid; consumers qualify with out_valid.
  - Latency is exactly 1 cycle. There is no backpressure or stall input.
- Reset:
  - On a rising clk with reset=1: result=0, zero=0, out_valid=0, overriding same-cycle inputs.
  - Combinational outputs are unaffected by reset.
  - Reset mid-stream discards the in-flight result; the first valid output follows one cycle after reset deasserts with in_valid=1.

Decomposition:
- Shared package:
  - opcode constants OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI
  - funct constants F_ADD, F_SUB, F_AND, F_OR, F_SLT, F_NOR
  - ALU codes ALU_AND=0000, ALU_OR=0001, ALU_ADD=0010, ALU_SUB=0110, ALU_SLT=0111, ALU_NOR=1100
  - aluop codes 00/01/10
- Sub-modules: purely combinational mips_alu_core (ctl, a, b -> out) is the natural one. Main decode and ALU control stay as always_comb blocks in the top.

Test Plan:
- R-type add: opcode=0, funct=0x20, a=5, b=7, in_valid=1 -> comb regdst=1, regwrite=1, aluop=10, aluctl=0010; next cycle result=12, zero=0, out_valid=1.
- R-type sub/slt/nor:
  - a=7, b=7, funct=0x22 -> result=0, zero=1.
  - a=0xFFFFFFFF, b=1, funct=0x2A -> result=1 (signed -1 < 1).
  - a=0, b=0, funct=0x27 -> result=0xFFFFFFFF.
- lw with negative imm: opcode=0x23, a=0x100, imm=0xFFFC -> alusrc=1, memread=1, memtoreg=1, aluctl=0010; result=0xFC.
- sw / beq / addi / unknown opcode:
  - sw 0x2B -> memwrite=1, regwrite=0.
  - beq 0x04, a=b=9 -> branch=1, aluctl=0110, zero=1.
  - addi 0x08, a=3, imm=0x0002 -> result=5.
  - opcode=0x3F -> all control outputs 0.
- Unknown funct / overflow: funct=0x3F, a=1, b=2 -> aluctl=0010, result=3. a=0xFFFFFFFF, b=1, add -> result=0, zero=1.
- Reset: drive valid add (result 12), assert reset on next edge with in_valid=1 -> result=0, zero=0, out_valid=0. Deassert -> first valid result appears one cycle later.

Source files
------------

// File: rtl/mips_decode_alu_pkg.sv
// Shared constants and control bundle for the MIPS decode/execute slice.
package mips_decode_alu_pkg;

  localparam int unsigned DATA_W   = 32;
  localparam int unsigned OP_W     = 6;
  localparam int unsigned FUNCT_W  = 6;
  localparam int unsigned IMM_W    = 16;
  localparam int unsigned ALUCTL_W = 4;
  localparam int unsigned ALUOP_W  = 2;

  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;

  localparam logic [FUNCT_W-1:0] F_ADD = 6'b100000;
  localparam logic [FUNCT_W-1:0] F_SUB = 6'b100010;
  localparam logic [FUNCT_W-1:0] F_AND = 6'b100100;
  localparam logic [FUNCT_W-1:0] F_OR  = 6'b100101;
  localparam logic [FUNCT_W-1:0] F_SLT = 6'b101010;
  localparam logic [FUNCT_W-1:0] F_NOR = 6'b100111;

  localparam logic [ALUCTL_W-1:0] ALU_AND = 4'b0000;
  localparam logic [ALUCTL_W-1:0] ALU_OR  = 4'b0001;
  localparam logic [ALUCTL_W-1:0] ALU_ADD = 4'b0010;
  localparam logic [ALUCTL_W-1:0] ALU_SUB = 4'b0110;
  localparam logic [ALUCTL_W-1:0] ALU_SLT = 4'b0111;
  localparam logic [ALUCTL_W-1:0] ALU_NOR = 4'b1100;

  localparam logic [ALUOP_W-1:0] ALUOP_ADD   = 2'b00;
  localparam logic [ALUOP_W-1:0] ALUOP_SUB   = 2'b01;
  localparam logic [ALUOP_W-1:0] ALUOP_FUNCT = 2'b10;

  typedef struct packed {
    logic               regdst;
    logic               alusrc;
    logic               memtoreg;
    logic               regwrite;
    logic               memread;
    logic               memwrite;
    logic               branch;
    logic [ALUOP_W-1:0] aluop;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_core.sv
// Purely combinational 32-bit ALU selected by a 4-bit operation code.
module mips_alu_core
  import mips_decode_alu_pkg::*;
(
  input  logic [ALUCTL_W-1:0] ctl,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  output logic [DATA_W-1:0]   out_c
);

  always_comb begin
    out_c = '0;
    unique case (ctl)
      ALU_AND: out_c = a & b;
      ALU_OR:  out_c = a | b;
      ALU_ADD: out_c = a + b;
      ALU_SUB: out_c = a - b;
      ALU_SLT: out_c = ($signed(a) < $signed(b)) ? DATA_W'(1) : '0;
      ALU_NOR: out_c = ~(a | b);
      default: out_c = '0;
    endcase
  end

endmodule

// File: rtl/mips_decode_alu.sv
// ID/EX slice: main control decode, ALU control decode and a registered ALU.
module mips_decode_alu
  import mips_decode_alu_pkg::*;
#(
  parameter int unsigned W = DATA_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [OP_W-1:0]     opcode,
  input  logic [FUNCT_W-1:0]  funct,
  input  logic [IMM_W-1:0]    imm,
  input  logic [W-1:0]        a,
  input  logic [W-1:0]        b,
  output logic                regdst,
  output logic                branch,
  output logic                memread,
  output logic                memwrite,
  output logic                memtoreg,
  output logic [ALUOP_W-1:0]  aluop,
  output logic                regwrite,
  output logic                alusrc,
  output logic [ALUCTL_W-1:0] aluctl,
  output logic [W-1:0]        result,
  output logic                zero,
  output logic                out_valid
);

  ctrl_t       ctrl;
  logic [W-1:0] alu_b;
  logic [W-1:0] alu_out;
  logic [W-1:0] result_d, result_q;
  logic         zero_d, zero_q;
  logic         out_valid_d, out_valid_q;

  // Main decode; unknown opcodes fall through as a NOP with no side effects.
  always_comb begin
    ctrl = '0;
    unique case (opcode)
      OP_RTYPE: ctrl = '{regdst: 1'b1, regwrite: 1'b1, aluop: ALUOP_FUNCT, default: 1'b0};
      OP_LW:    ctrl = '{alusrc: 1'b1, memtoreg: 1'b1, regwrite: 1'b1, memread: 1'b1,
                         aluop: ALUOP_ADD, default: 1'b0};
      OP_SW:    ctrl = '{alusrc: 1'b1, memwrite: 1'b1, aluop: ALUOP_ADD, default: 1'b0};
      OP_BEQ:   ctrl = '{branch: 1'b1, aluop: ALUOP_SUB, default: 1'b0};
      OP_ADDI:  ctrl = '{alusrc: 1'b1, regwrite: 1'b1, aluop: ALUOP_ADD, default: 1'b0};
      default:  ctrl = '0;
    endcase
  end

  assign regdst   = ctrl.regdst;
  assign alusrc   = ctrl.alusrc;
  assign memtoreg = ctrl.memtoreg;
  assign regwrite = ctrl.regwrite;
  assign memread  = ctrl.memread;
  assign memwrite = ctrl.memwrite;
  assign branch   = ctrl.branch;
  assign aluop    = ctrl.aluop;

  // ALU control; unknown funct and aluop 11 default to add.
  always_comb begin
    aluctl = ALU_ADD;
    unique case (ctrl.aluop)
      ALUOP_ADD: aluctl = ALU_ADD;
      ALUOP_SUB: aluctl = ALU_SUB;
      ALUOP_FUNCT: begin
        unique case (funct)
          F_ADD:   aluctl = ALU_ADD;
          F_SUB:   aluctl = ALU_SUB;
          F_AND:   aluctl = ALU_AND;
          F_OR:    aluctl = ALU_OR;
          F_SLT:   aluctl = ALU_SLT;
          F_NOR:   aluctl = ALU_NOR;
          default: aluctl = ALU_ADD;
        endcase
      end
      default:   aluctl = ALU_ADD;
    endcase
  end

  assign alu_b = ctrl.alusrc ? {{(W-IMM_W){imm[IMM_W-1]}}, imm} : b;

  mips_alu_core u_alu (
    .ctl   (aluctl),
    .a     (a),
    .b     (alu_b),
    .out_c (alu_out)
  );

  // Result and zero track the ALU every cycle; consumers qualify with out_valid.
  always_comb begin
    result_d    = alu_out;
    zero_d      = (alu_out == '0);
    out_valid_d = in_valid;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      result_q    <= '0;
      zero_q      <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      result_q    <= result_d;
      zero_q      <= zero_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign result    = result_q;
  assign zero      = zero_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mips_decode_alu.sv
// Scoreboard bench for mips_decode_alu: comb controls checked on drive, registered outputs on pop.
module tb_mips_decode_alu;

  typedef struct packed {
    logic        valid;
    logic [31:0] res;
    logic        zero;
    logic [15:0] id;
  } exp_t;

  localparam logic [8:0] CTL_R    = 9'b100100010;
  localparam logic [8:0] CTL_LW   = 9'b011110000;
  localparam logic [8:0] CTL_SW   = 9'b010001000;
  localparam logic [8:0] CTL_BEQ  = 9'b000000101;
  localparam logic [8:0] CTL_ADDI = 9'b010100000;
  localparam logic [8:0] CTL_NOP  = 9'b000000000;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic [5:0]  opcode, funct;
  logic [15:0] imm;
  logic [31:0] a, b;
  logic        regdst, branch, memread, memwrite, memtoreg, regwrite, alusrc;
  logic [1:0]  aluop;
  logic [3:0]  aluctl;
  logic [31:0] result;
  logic        zero, out_valid;

  int   checks   = 0;
  int   failures = 0;
  int   n_id     = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  mips_decode_alu dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .opcode(opcode), .funct(funct),
    .imm(imm), .a(a), .b(b), .regdst(regdst), .branch(branch), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .aluop(aluop), .regwrite(regwrite),
    .alusrc(alusrc), .aluctl(aluctl), .result(result), .zero(zero), .out_valid(out_valid)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One cycle of stimulus: check comb decode now, queue the registered expectation.
  task automatic drive(input logic rst, input logic vld, input logic [5:0] op,
                       input logic [5:0] fn, input logic [15:0] im,
                       input logic [31:0] av, input logic [31:0] bv,
                       input logic [8:0] exp_ctl, input logic [3:0] exp_alu,
                       input logic [31:0] exp_res);
    exp_t e;
    @(negedge clk);
    reset = rst; in_valid = vld; opcode = op; funct = fn; imm = im; a = av; b = bv;
    #1;
    check($sformatf("ctl%0d", n_id),
          32'({regdst, alusrc, memtoreg, regwrite, memread, memwrite, branch, aluop}),
          32'(exp_ctl));
    check($sformatf("aluctl%0d", n_id), 32'(aluctl), 32'(exp_alu));
    e.valid = rst ? 1'b0 : vld;
    e.res   = rst ? 32'h0 : exp_res;
    e.zero  = rst ? 1'b0 : (exp_res == 32'h0);
    e.id    = 16'(n_id);
    sb_q.push_back(e);
    n_id++;
  endtask

  // Monitor: every captured edge has exactly one queued expectation.
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      check($sformatf("valid%0d", e.id), 32'(out_valid), 32'(e.valid));
      check($sformatf("res%0d", e.id), result, e.res);
      check($sformatf("zero%0d", e.id), 32'(zero), 32'(e.zero));
    end
  end

  initial begin
    reset = 1'b1; in_valid = 1'b0; opcode = '0; funct = '0; imm = '0; a = '0; b = '0;
    drive(1, 0, 6'h00, 6'h20, 16'h0000, 32'd0, 32'd0, CTL_R, 4'b0010, 32'd0);
    drive(1, 0, 6'h00, 6'h20, 16'h0000, 32'd0, 32'd0, CTL_R, 4'b0010, 32'd0);

    // R-type group; imm is nonzero to expose a wrong B-operand select
    drive(0, 1, 6'h00, 6'h20, 16'h8000, 32'd5, 32'd7, CTL_R, 4'b0010, 32'd12);
    drive(0, 1, 6'h00, 6'h22, 16'h8000, 32'd7, 32'd7, CTL_R, 4'b0110, 32'd0);
    drive(0, 1, 6'h00, 6'h2A, 16'h8000, 32'hFFFF_FFFF, 32'd1, CTL_R, 4'b0111, 32'd1);
    drive(0, 1, 6'h00, 6'h2A, 16'h8000, 32'd1, 32'hFFFF_FFFF, CTL_R, 4'b0111, 32'd0);
    drive(0, 1, 6'h00, 6'h27, 16'h8000, 32'd0, 32'd0, CTL_R, 4'b1100, 32'hFFFF_FFFF);
    drive(0, 1, 6'h00, 6'h24, 16'h8000, 32'h0000_F0F0, 32'h0000_FF00, CTL_R, 4'b0000, 32'h0000_F000);
    drive(0, 1, 6'h00, 6'h25, 16'h8000, 32'h0000_F0F0, 32'h0000_0F00, CTL_R, 4'b0001, 32'h0000_FFF0);
    drive(0, 1, 6'h00, 6'h3F, 16'h8000, 32'd1, 32'd2, CTL_R, 4'b0010, 32'd3);
    drive(0, 1, 6'h00, 6'h20, 16'h8000, 32'hFFFF_FFFF, 32'd1, CTL_R, 4'b0010, 32'd0);

    // Memory, branch and immediate forms; b is junk where alusrc selects imm
    drive(0, 1, 6'h23, 6'h00, 16'hFFFC, 32'h100, 32'hDEAD_BEEF, CTL_LW, 4'b0010, 32'hFC);
    drive(0, 1, 6'h2B, 6'h00, 16'h0004, 32'h10, 32'hDEAD_BEEF, CTL_SW, 4'b0010, 32'h14);
    drive(0, 1, 6'h04, 6'h2A, 16'h0000, 32'd9, 32'd9, CTL_BEQ, 4'b0110, 32'd0);
    drive(0, 1, 6'h04, 6'h00, 16'h0000, 32'd9, 32'd4, CTL_BEQ, 4'b0110, 32'd5);
    drive(0, 1, 6'h08, 6'h22, 16'h0002, 32'd3, 32'd100, CTL_ADDI, 4'b0010, 32'd5);
    drive(0, 1, 6'h08, 6'h00, 16'hFFFF, 32'd3, 32'd100, CTL_ADDI, 4'b0010, 32'd2);
    drive(0, 1, 6'h3F, 6'h22, 16'hFFFF, 32'd1, 32'd2, CTL_NOP, 4'b0010, 32'd3);

    // Idle cycle: result still tracks the ALU but out_valid drops
    drive(0, 0, 6'h00, 6'h22, 16'h0000, 32'd10, 32'd4, CTL_R, 4'b0110, 32'd6);

    // Reset overrides an in-flight valid add, then the stream resumes
    drive(0, 1, 6'h00, 6'h20, 16'h0000, 32'd5, 32'd7, CTL_R, 4'b0010, 32'd12);
    drive(1, 1, 6'h00, 6'h20, 16'h0000, 32'd5, 32'd7, CTL_R, 4'b0010, 32'd12);
    drive(0, 1, 6'h00, 6'h20, 16'h0000, 32'd5, 32'd7, CTL_R, 4'b0010, 32'd12);
    drive(0, 1, 6'h00, 6'h22, 16'h0000, 32'd3, 32'd5, CTL_R, 4'b0110, 32'hFFFF_FFFE);

    repeat (3) @(negedge clk);
    check("drain", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
